sgmii_rx_buf: RTL and testbench
===============================

# sgmii_rx_buf

Receive-side counterpart of the SGMII transmit path: consumes decoded TBI bytes (data/K flag/code-error) in the `tbi_tx_clk` domain, parses /C/ and /I/ ordered sets, and drives the `sgmii_autoneg_start/ack/idle` handshake inputs of the transmit buffer. Once autonegotiation is idle, it strips /S/, /T/, /R/ and /E/ framing and presents the frame as GMII receive cycles. It sits between the 8b/10b decoder and the MAC receive path.

## Interface
- `IDLE_COUNT`, 8: consecutive /I/ sets needed to assert `sgmii_autoneg_idle`.
- `TIMEOUT_CYCLES`, 4096: cycles without a K28.5 before sync is declared lost (12-bit counter).
- `MATCH_COUNT`, 3: consecutive identical config words needed for ability match.
- `tbi_tx_clk` in 1: byte clock.
- `rst` in 1: reset, asynchronous, active-high; clock `tbi_tx_clk`.
- `rx_byte` in 8: decoded byte.
- `rx_is_k` in 1: byte is a K character.
- `rx_err` in 1: code or disparity violation on this byte.
- `sgmii_autoneg_start` out 1: partner sending nonzero config.
- `sgmii_autoneg_ack` out 1: partner config carries ACK (bit 14).
- `sgmii_autoneg_idle` out 1: partner has moved to idle after ACK.
- `link_config` out 16: last ability-matched partner config word.
- `sync_ok` out 1: K28.5 seen within the timeout window.
- `gmii_rxd` out 8: receive data.
- `gmii_rx_dv` out 1: receive data valid.
- `gmii_rx_er` out 1: receive error.

## Operation
- **Ordered-set parser states:** `OS_IDLE`, `OS_K`, `OS_C_LO`, `OS_C_HI`.
  - K28.5 (`BC`, k=1) from any non-packet state goes to `OS_K`.
  - From `OS_K`: `B5`/`42` (k=0) go to `OS_C_LO`; `C5`/`50` count one /I/ and go to `OS_IDLE`; anything else goes to `OS_IDLE`.
  - `OS_C_LO` captures the low byte. `OS_C_HI` captures the high byte and completes the word.
- **Ability match:** a completed word equal to the previous word increments the match counter (saturating); a different word reloads it to 1. When the counter reaches `MATCH_COUNT`:
  - `link_config` latches the word.
  - `start` is set if the word is nonzero.
  - `ack` is set if `start` and bit 14 is set.
- **Restart:** a matched zero word clears `start`, `ack` and `idle`.
- **Idle count:** /I/ sets increment the idle counter (saturating at `IDLE_COUNT`). Any completed config word clears it. `idle` is set when `ack` and the counter equals `IDLE_COUNT`.
- **Sync:**
  - Timeout counter reloads on every K28.5.
  - On reaching `TIMEOUT_CYCLES`, `sync_ok` drops and `start`, `ack`, `idle` and the counters clear.
  - `sync_ok` rises on the next K28.5.
- **Packet decode** (only while `idle`=1):
  - /S/ (`FB`, k) gives dv=1, rxd=`55`.
  - Data (k=0, no rx_err) gives dv=1, rxd=byte.
  - /E/ (`FE`, k) or rx_err gives dv=1, er=1, rxd=`00`.
  - /T/ (`FD`, k) gives dv=0 and ends the packet; the following /R/ (`F7`) is discarded.
  - K28.5 or any other K inside a packet gives one cycle of dv=1, er=1, then ends the packet. K28.5 also re-enters the parser.
- /S/ received while `idle`=0 is ignored (no GMII output).
- Without `SGMII_RX_STATS_EN`, rx_err outside a packet has no effect beyond resetting the parser to `OS_IDLE`.

## Timing
- Reset values:
  - `sgmii_autoneg_start`, `sgmii_autoneg_ack`, `sgmii_autoneg_idle`, `sync_ok` = 0
  - `link_config` = `0000`
  - `gmii_rxd` = `00`, `gmii_rx_dv` = 0, `gmii_rx_er` = 0
  - Parser is in `OS_IDLE`; all counters are 0.
- GMII outputs are registered: input byte at cycle n appears at cycle n+1.
- Flag and `link_config` updates occur the cycle after the high config byte (or the /I/ second byte) is sampled.
- Simultaneous timeout and K28.5 in the same cycle: the K28.5 wins and the counter reloads.
- Reset mid-packet: outputs drop to reset values immediately; no truncated frame is flagged.
- A restart and an /I/ completing in the same cycle cannot occur; the parser completes one set per cycle at most.

## Configuration
- `SGMII_RX_STATS_EN` defined: adds output ports `rx_pkt_cnt[15:0]` and `rx_err_cnt[15:0]`.
  - `rx_pkt_cnt` increments on every /T/ termination.
  - `rx_err_cnt` increments on every cycle with `gmii_rx_er`=1 and on every rx_err outside a packet.
  - Both counters wrap at 16 bits and reset to 0.
- Not defined: neither port nor counter exists; all other behaviour is identical.

## Test plan
- **Config match:** send 3× (BC B5 80 01 / BC 42 80 01) → `start`=1, `link_config`=`0180`, `ack`=0.
- **ACK:** then 3× config with high byte `C1` → `ack`=1, `link_config`=`C180`.
- **Idle and packet:** then 8× (BC C5 / BC 50) → `idle`=1. Then send FB 55 D5 AA FD F7 → GMII dv=1 for 4 cycles with rxd 55,55,D5,AA, each one cycle after input, then dv=0.
- **Error inside packet:** FB 11 FE 22 FD → er=1 only on the FE cycle. An rx_err on a data byte → er=1 with rxd=00.
- **Restart and sync loss:** 3× zero config words → `start`/`ack`/`idle` all 0. Separately, 4096 cycles of `00` data with no BC → `sync_ok`=0 and all flags clear.
- **Stats (with `SGMII_RX_STATS_EN`):** two good frames and one frame containing FE → `rx_pkt_cnt`=3, `rx_err_cnt`=1.

Source files
------------

// File: rtl/sgmii_rx_buf.sv
// sgmii_rx_buf: SGMII receive side. Parses /C/ and /I/ ordered sets from decoded
// TBI bytes, drives the autonegotiation handshake flags, tracks comma sync and
// converts /S/ .. /T/ framed packets into registered GMII receive cycles.
// Optional build macro: SGMII_RX_STATS_EN adds rx_pkt_cnt / rx_err_cnt ports.
module sgmii_rx_buf #(
  parameter int unsigned IDLE_COUNT     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned MATCH_COUNT    = 3
) (
  input  logic        tbi_tx_clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_is_k,
  input  logic        rx_err,
  output logic        sgmii_autoneg_start,
  output logic        sgmii_autoneg_ack,
  output logic        sgmii_autoneg_idle,
  output logic [15:0] link_config,
  output logic        sync_ok,
  output logic [7:0]  gmii_rxd,
  output logic        gmii_rx_dv,
  output logic        gmii_rx_er
`ifdef SGMII_RX_STATS_EN
  ,
  output logic [15:0] rx_pkt_cnt,
  output logic [15:0] rx_err_cnt
`endif
);

  localparam int unsigned TmoW   = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned IdleW  = $clog2(IDLE_COUNT + 1);
  localparam int unsigned MatchW = $clog2(MATCH_COUNT + 1);

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K_S   = 8'hFB;
  localparam logic [7:0] K_T   = 8'hFD;
  localparam logic [7:0] K_E   = 8'hFE;

  typedef enum logic [1:0] {OS_IDLE, OS_K, OS_C_LO, OS_C_HI} os_state_e;

  os_state_e         state_q, state_d;
  logic              in_pkt_q, in_pkt_d;
  logic [7:0]        word_lo_q;
  logic [15:0]       prev_word_q;
  logic [MatchW-1:0] match_cnt_q, match_nxt;
  logic [IdleW-1:0]  idle_cnt_q, idle_nxt;
  logic [TmoW-1:0]   tmo_cnt_q;

  logic        is_comma, timeout, word_done, idle_done, pkt_start, matched;
  logic [15:0] word;
  logic        dv_d, er_d, term_d;
  logic [7:0]  rxd_d;

  // Ordered-set event decode and saturating counter next values
  always_comb begin
    // An errored byte is never trusted as a comma
    is_comma  = rx_is_k && (rx_byte == K28_5) && !rx_err;
    timeout   = (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) && !is_comma;
    word      = {rx_byte, word_lo_q};
    word_done = !in_pkt_q && !rx_err && !rx_is_k && (state_q == OS_C_HI);
    idle_done = !in_pkt_q && !rx_err && !rx_is_k && (state_q == OS_K) &&
                ((rx_byte == 8'hC5) || (rx_byte == 8'h50));
    pkt_start = !in_pkt_q && sgmii_autoneg_idle && rx_is_k && !rx_err && (rx_byte == K_S);

    if (word != prev_word_q) begin
      match_nxt = MatchW'(1);
    end else if (match_cnt_q == MatchW'(MATCH_COUNT)) begin
      match_nxt = match_cnt_q;
    end else begin
      match_nxt = match_cnt_q + MatchW'(1);
    end
    matched = word_done && (match_nxt == MatchW'(MATCH_COUNT));

    if (idle_cnt_q == IdleW'(IDLE_COUNT)) begin
      idle_nxt = idle_cnt_q;
    end else begin
      idle_nxt = idle_cnt_q + IdleW'(1);
    end
  end

  // Parser next state; frozen in OS_IDLE inside a packet except for a comma
  always_comb begin
    state_d = OS_IDLE;
    if (in_pkt_q) begin
      state_d = is_comma ? OS_K : OS_IDLE;
    end else if (rx_err) begin
      state_d = OS_IDLE;
    end else if (is_comma) begin
      state_d = OS_K;
    end else begin
      case (state_q)
        OS_K: begin
          if (!rx_is_k && ((rx_byte == 8'hB5) || (rx_byte == 8'h42))) state_d = OS_C_LO;
        end
        OS_C_LO: begin
          if (!rx_is_k) state_d = OS_C_HI;
        end
        default: state_d = OS_IDLE;
      endcase
    end
  end

  // Packet decode into next GMII cycle
  always_comb begin
    dv_d     = 1'b0;
    er_d     = 1'b0;
    rxd_d    = 8'h00;
    term_d   = 1'b0;
    in_pkt_d = in_pkt_q;
    if (in_pkt_q) begin
      if (rx_err) begin
        dv_d = 1'b1;
        er_d = 1'b1;
      end else if (rx_is_k) begin
        case (rx_byte)
          K_E: begin
            dv_d = 1'b1;
            er_d = 1'b1;
          end
          K_T: begin
            in_pkt_d = 1'b0;
            term_d   = 1'b1;
          end
          default: begin
            // Unexpected K (including a comma) aborts the frame with one error cycle
            dv_d     = 1'b1;
            er_d     = 1'b1;
            in_pkt_d = 1'b0;
          end
        endcase
      end else begin
        dv_d  = 1'b1;
        rxd_d = rx_byte;
      end
    end else if (pkt_start) begin
      dv_d     = 1'b1;
      rxd_d    = 8'h55;
      in_pkt_d = 1'b1;
    end
    if (timeout) begin
      dv_d     = 1'b0;
      er_d     = 1'b0;
      rxd_d    = 8'h00;
      term_d   = 1'b0;
      in_pkt_d = 1'b0;
    end
  end

  // Parser, autonegotiation flags, sync tracking and GMII output registers
  always_ff @(posedge tbi_tx_clk or posedge rst) begin
    if (rst) begin
      state_q             <= OS_IDLE;
      in_pkt_q            <= 1'b0;
      word_lo_q           <= 8'h00;
      prev_word_q         <= 16'h0000;
      match_cnt_q         <= '0;
      idle_cnt_q          <= '0;
      tmo_cnt_q           <= '0;
      sgmii_autoneg_start <= 1'b0;
      sgmii_autoneg_ack   <= 1'b0;
      sgmii_autoneg_idle  <= 1'b0;
      link_config         <= 16'h0000;
      sync_ok             <= 1'b0;
      gmii_rxd            <= 8'h00;
      gmii_rx_dv          <= 1'b0;
      gmii_rx_er          <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_pkt_q   <= in_pkt_d;
      gmii_rxd   <= rxd_d;
      gmii_rx_dv <= dv_d;
      gmii_rx_er <= er_d;

      if (!in_pkt_q && (state_q == OS_C_LO)) word_lo_q <= rx_byte;

      if (is_comma) begin
        tmo_cnt_q <= '0;
        sync_ok   <= 1'b1;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
        if (timeout) sync_ok <= 1'b0;
      end

      if (timeout) begin
        sgmii_autoneg_start <= 1'b0;
        sgmii_autoneg_ack   <= 1'b0;
        sgmii_autoneg_idle  <= 1'b0;
        match_cnt_q         <= '0;
        idle_cnt_q          <= '0;
        prev_word_q         <= 16'h0000;
      end else if (word_done) begin
        prev_word_q <= word;
        match_cnt_q <= match_nxt;
        idle_cnt_q  <= '0;
        if (matched) begin
          link_config <= word;
          if (word != 16'h0000) begin
            sgmii_autoneg_start <= 1'b1;
            sgmii_autoneg_ack   <= word[14];
          end else begin
            sgmii_autoneg_start <= 1'b0;
            sgmii_autoneg_ack   <= 1'b0;
            sgmii_autoneg_idle  <= 1'b0;
          end
        end
      end else if (idle_done) begin
        idle_cnt_q <= idle_nxt;
        if (sgmii_autoneg_ack && (idle_nxt == IdleW'(IDLE_COUNT))) sgmii_autoneg_idle <= 1'b1;
      end
    end
  end

`ifdef SGMII_RX_STATS_EN
  // Frame and error statistics, wrapping at 16 bits
  always_ff @(posedge tbi_tx_clk or posedge rst) begin
    if (rst) begin
      rx_pkt_cnt <= 16'h0000;
      rx_err_cnt <= 16'h0000;
    end else begin
      if (term_d) rx_pkt_cnt <= rx_pkt_cnt + 16'h0001;
      if (er_d || (!in_pkt_q && rx_err)) rx_err_cnt <= rx_err_cnt + 16'h0001;
    end
  end
`else
  logic unused_term;
  assign unused_term = term_d;
`endif

endmodule

// File: tb/tb_sgmii_rx_buf.sv
// Directed bench for sgmii_rx_buf: autonegotiation, packet decode, restart,
// sync loss, asynchronous reset and (when built with SGMII_RX_STATS_EN) stats.
module tb_sgmii_rx_buf;

  logic        tbi_tx_clk;
  logic        rst;
  logic [7:0]  rx_byte;
  logic        rx_is_k;
  logic        rx_err;
  logic        sgmii_autoneg_start;
  logic        sgmii_autoneg_ack;
  logic        sgmii_autoneg_idle;
  logic [15:0] link_config;
  logic        sync_ok;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
`ifdef SGMII_RX_STATS_EN
  logic [15:0] rx_pkt_cnt;
  logic [15:0] rx_err_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  sgmii_rx_buf dut (
    .tbi_tx_clk          (tbi_tx_clk),
    .rst                 (rst),
    .rx_byte             (rx_byte),
    .rx_is_k             (rx_is_k),
    .rx_err              (rx_err),
    .sgmii_autoneg_start (sgmii_autoneg_start),
    .sgmii_autoneg_ack   (sgmii_autoneg_ack),
    .sgmii_autoneg_idle  (sgmii_autoneg_idle),
    .link_config         (link_config),
    .sync_ok             (sync_ok),
    .gmii_rxd            (gmii_rxd),
    .gmii_rx_dv          (gmii_rx_dv),
    .gmii_rx_er          (gmii_rx_er)
`ifdef SGMII_RX_STATS_EN
    ,
    .rx_pkt_cnt          (rx_pkt_cnt),
    .rx_err_cnt          (rx_err_cnt)
`endif
  );

  initial tbi_tx_clk = 1'b0;
  always #5 tbi_tx_clk = ~tbi_tx_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One byte per clock; returns 1 time unit after the sampling edge
  task automatic tx(input logic [7:0] b, input logic k, input logic e);
    rx_byte = b;
    rx_is_k = k;
    rx_err  = e;
    @(posedge tbi_tx_clk);
    #1;
  endtask

  task automatic send_cfg(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      tx(8'hBC, 1'b1, 1'b0);
      tx((i % 2 == 1) ? 8'h42 : 8'hB5, 1'b0, 1'b0);
      tx(w[7:0], 1'b0, 1'b0);
      tx(w[15:8], 1'b0, 1'b0);
    end
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) begin
      tx(8'hBC, 1'b1, 1'b0);
      tx((i % 2 == 1) ? 8'h50 : 8'hC5, 1'b0, 1'b0);
    end
  endtask

  function automatic logic [31:0] gm(input logic dv, input logic er, input logic [7:0] d);
    return {22'd0, dv, er, d};
  endfunction

  initial begin
    rst     = 1'b1;
    rx_byte = 8'h00;
    rx_is_k = 1'b0;
    rx_err  = 1'b0;
    repeat (3) @(posedge tbi_tx_clk);
    #1;
    check("rst_start", sgmii_autoneg_start, 0);
    check("rst_ack", sgmii_autoneg_ack, 0);
    check("rst_idle", sgmii_autoneg_idle, 0);
    check("rst_sync", sync_ok, 0);
    check("rst_cfg", link_config, 32'h0000);
    check("rst_gmii", gm(gmii_rx_dv, gmii_rx_er, gmii_rxd), gm(0, 0, 8'h00));
    rst = 1'b0;

    // Ability match needs three identical words
    send_cfg(16'h0180, 2);
    check("cfg2_start", sgmii_autoneg_start, 0);
    send_cfg(16'h0180, 1);
    check("cfg3_start", sgmii_autoneg_start, 1);
    check("cfg3_link", link_config, 32'h0180);
    check("cfg3_ack", sgmii_autoneg_ack, 0);
    check("cfg3_sync", sync_ok, 1);
    send_cfg(16'h0180, 3);

    send_cfg(16'hC180, 3);
    check("ack_ack", sgmii_autoneg_ack, 1);
    check("ack_link", link_config, 32'hC180);

    send_idle(7);
    check("idle7", sgmii_autoneg_idle, 0);
    send_idle(1);
    check("idle8", sgmii_autoneg_idle, 1);

    // Good frame
    tx(8'hFB, 1'b1, 1'b0);
    check("pk_s", gm(gmii_rx_dv, gmii_rx_er, gmii_rxd), gm(1, 0, 8'h55));
    tx(8'h55, 1'b0, 1'b0);
    check("pk_d0", gm(gmii_rx_dv, gmii_rx_er, gmii_rxd), gm(1, 0, 8'h55));
    tx(8'hD5, 1'b0, 1'b0);
    check("pk_d1", gm(gmii_rx_dv, gmii_rx_er, gmii_rxd), gm(1, 0, 8'hD5));
    tx(8'hAA, 1'b0, 1'b0);
    check("pk_d2", gm(gmii_rx_dv, gmii_rx_er, gmii_rxd), gm(1, 0, 8'hAA));
    tx(8'hFD, 1'b1, 1'b0);
    check("pk_t", gmii_rx_dv, 0);
    tx(8'hF7, 1'b1, 1'b0);
    check("pk_r", gmii_rx_dv, 0);

    // /E/ and rx_err inside a frame
    tx(8'hFB, 1'b1, 1'b0);
    tx(8'h11, 1'b0, 1'b0);
    check("er_d0", gm(gmii_rx_dv, gmii_rx_er, gmii_rxd), gm(1, 0, 8'h11));
    tx(8'hFE, 1'b1, 1'b0);
    check("er_e", gm(gmii_rx_dv, gmii_rx_er, gmii_rxd), gm(1, 1, 8'h00));
    tx(8'h22, 1'b0, 1'b0);
    check("er_d1", gm(gmii_rx_dv, gmii_rx_er, gmii_rxd), gm(1, 0, 8'h22));
    tx(8'hFD, 1'b1, 1'b0);
    check("er_t", gmii_rx_dv, 0);
    tx(8'hFB, 1'b1, 1'b0);
    tx(8'h33, 1'b0, 1'b1);
    check("er_rxerr", gm(gmii_rx_dv, gmii_rx_er, gmii_rxd), gm(1, 1, 8'h00));
    tx(8'hFD, 1'b1, 1'b0);

    // Comma inside a frame: one error cycle, frame ends
    tx(8'hFB, 1'b1, 1'b0);
    tx(8'h44, 1'b0, 1'b0);
    tx(8'hBC, 1'b1, 1'b0);
    check("k_abort", gm(gmii_rx_dv, gmii_rx_er, gmii_rxd), gm(1, 1, 8'h00));
    tx(8'hC5, 1'b0, 1'b0);
    check("k_after", gmii_rx_dv, 0);

    // Restart with matched zero config
    send_cfg(16'h0000, 3);
    check("rs_start", sgmii_autoneg_start, 0);
    check("rs_ack", sgmii_autoneg_ack, 0);
    check("rs_idle", sgmii_autoneg_idle, 0);
    check("rs_link", link_config, 32'h0000);
    tx(8'hFB, 1'b1, 1'b0);
    check("s_not_idle", gmii_rx_dv, 0);

    // Sync loss: 3 non-comma bytes follow the last comma inside send_cfg
    send_cfg(16'h4001, 3);
    check("sy_ack", sgmii_autoneg_ack, 1);
    repeat (4092) tx(8'h00, 1'b0, 1'b0);
    check("sy_4095_sync", sync_ok, 1);
    check("sy_4095_start", sgmii_autoneg_start, 1);
    tx(8'h00, 1'b0, 1'b0);
    check("sy_4096_sync", sync_ok, 0);
    check("sy_4096_start", sgmii_autoneg_start, 0);
    check("sy_4096_ack", sgmii_autoneg_ack, 0);
    tx(8'hBC, 1'b1, 1'b0);
    check("sy_regain", sync_ok, 1);

    // Asynchronous reset in the middle of a frame
    send_cfg(16'h4001, 3);
    send_idle(8);
    check("ar_idle", sgmii_autoneg_idle, 1);
    tx(8'hFB, 1'b1, 1'b0);
    tx(8'h12, 1'b0, 1'b0);
    check("ar_pre", gm(gmii_rx_dv, gmii_rx_er, gmii_rxd), gm(1, 0, 8'h12));
    #2 rst = 1'b1;
    #1;
    check("ar_gmii", gm(gmii_rx_dv, gmii_rx_er, gmii_rxd), gm(0, 0, 8'h00));
    check("ar_idle_clr", sgmii_autoneg_idle, 0);
    @(posedge tbi_tx_clk);
    #1 rst = 1'b0;

`ifdef SGMII_RX_STATS_EN
    send_cfg(16'h4001, 3);
    send_idle(8);
    tx(8'hFB, 1'b1, 1'b0); tx(8'h01, 1'b0, 1'b0); tx(8'hFD, 1'b1, 1'b0); tx(8'hF7, 1'b1, 1'b0);
    tx(8'hFB, 1'b1, 1'b0); tx(8'h02, 1'b0, 1'b0); tx(8'hFD, 1'b1, 1'b0); tx(8'hF7, 1'b1, 1'b0);
    tx(8'hFB, 1'b1, 1'b0); tx(8'hFE, 1'b1, 1'b0); tx(8'hFD, 1'b1, 1'b0); tx(8'hF7, 1'b1, 1'b0);
    check("st_pkt", rx_pkt_cnt, 3);
    check("st_err", rx_err_cnt, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
